// File: rtl/branch_pc_unit.sv
// Program-counter sequencer for the Mini SRC datapath.
// Applies INC, conditional BRANCH, JR and JAL under a valid/ready handshake.
module branch_pc_unit #(
    parameter int                 DATA_W   = 32,
    parameter int                 OFFSET_W = 19,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              cond_in,
    output logic              op_ready,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] link_out,
    output logic              link_we,
    output logic              taken,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_JR  = 2'b10;
    localparam logic [1:0] OP_JAL = 2'b11;

    state_t              state;
    logic [OFFSET_W-1:0] offset_q;
    logic [DATA_W-1:0]   offset_sext;
    logic                unused_ir_bits;

    assign offset_sext = {{(DATA_W-OFFSET_W){offset_q[OFFSET_W-1]}}, offset_q};
    assign unused_ir_bits = ^ir[DATA_W-1:OFFSET_W];
    assign op_ready = (state == IDLE);

    // Only the branch needs its operand beyond the accept edge.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            pc_out   <= RESET_PC;
            link_out <= '0;
            link_we  <= 1'b0;
            taken    <= 1'b0;
            done     <= 1'b0;
            offset_q <= '0;
        end else begin
            done    <= 1'b0;
            link_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        taken    <= 1'b0;
                        offset_q <= ir[OFFSET_W-1:0];
                        case (op_code)
                            OP_INC: begin
                                pc_out <= pc_out + DATA_W'(1);
                                state  <= DONE;
                                done   <= 1'b1;
                            end
                            OP_BR: begin
                                state <= COND;
                            end
                            OP_JR: begin
                                pc_out <= bus_in;
                                state  <= DONE;
                                done   <= 1'b1;
                            end
                            OP_JAL: begin
                                link_out <= pc_out;
                                pc_out   <= bus_in;
                                link_we  <= 1'b1;
                                state    <= DONE;
                                done     <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                COND: begin
                    if (cond_in) begin
                        pc_out <= pc_out + offset_sext;
                        taken  <= 1'b1;
                    end
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit against a simple PC/link model.
module tb_branch_pc_unit;

    logic        clk;
    logic        clear;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] ir;
    logic [31:0] bus_in;
    logic        cond_in;
    logic        op_ready;
    logic [31:0] pc_out;
    logic [31:0] link_out;
    logic        link_we;
    logic        taken;
    logic        done;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_link;
    logic        m_taken;

    branch_pc_unit dut (
        .clock    (clk),
        .clear    (clear),
        .op_valid (op_valid),
        .op_code  (op_code),
        .ir       (ir),
        .bus_in   (bus_in),
        .cond_in  (cond_in),
        .op_ready (op_ready),
        .pc_out   (pc_out),
        .link_out (link_out),
        .link_we  (link_we),
        .taken    (taken),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sext19(input logic [31:0] v);
        int off;
        off = int'($signed(v[18:0]));
        return 32'(off);
    endfunction

    // Setup helper: jump to a known PC and return to IDLE.
    task automatic set_pc(input logic [31:0] target);
        op_valid = 1'b1;
        op_code  = 2'b10;
        bus_in   = target;
        tick();
        op_valid = 1'b0;
        tick();
        m_pc    = target;
        m_taken = 1'b0;
    endtask

    task automatic test_reset();
        clear    = 1'b1;
        op_valid = 1'b0;
        op_code  = 2'b00;
        ir       = '0;
        bus_in   = '0;
        cond_in  = 1'b0;
        tick();
        tick();
        total++;
        if (pc_out !== 32'h0 || op_ready !== 1'b1 || done !== 1'b0 ||
            taken !== 1'b0 || link_we !== 1'b0 || link_out !== 32'h0) begin
            $display("FAIL reset: pc=%h rdy=%b done=%b tk=%b lwe=%b lnk=%h",
                     pc_out, op_ready, done, taken, link_we, link_out);
        end else passed++;
        clear = 1'b0;
        m_pc = 0; m_link = 0; m_taken = 0;
        tick();
        total++;
        if (pc_out !== 32'h0 || done !== 1'b0) begin
            $display("FAIL idle_no_valid: pc=%h done=%b want 0/0", pc_out, done);
        end else passed++;
    endtask

    task automatic test_inc();
        op_valid = 1'b1;
        op_code  = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (pc_out !== 32'(i) || done !== 1'b1 || op_ready !== 1'b0) begin
                $display("FAIL inc_done%0d: pc=%h done=%b rdy=%b want %h/1/0",
                         i, pc_out, done, op_ready, 32'(i));
            end else passed++;
            tick();
            total++;
            if (pc_out !== 32'(i) || done !== 1'b0 || op_ready !== 1'b1) begin
                $display("FAIL inc_idle%0d: pc=%h done=%b rdy=%b want %h/0/1",
                         i, pc_out, done, op_ready, 32'(i));
            end else passed++;
        end
        op_valid = 1'b0;
        m_pc = 32'd3;
    endtask

    task automatic test_branch();
        logic [18:0] offs [3];
        logic        conds[3];
        logic [31:0] exp_pc;
        offs[0] = 19'h0000C; conds[0] = 1'b1;
        offs[1] = 19'h7FFFC; conds[1] = 1'b1;
        offs[2] = 19'h7FFFC; conds[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_pc(32'h10);
            op_valid = 1'b1;
            op_code  = 2'b01;
            ir       = {$urandom_range(0, 8191), offs[k]};
            cond_in  = ~conds[k];
            tick();
            op_valid = 1'b0;
            ir       = $urandom;
            total++;
            if (state_cond_ok() !== 1'b1) begin
                $display("FAIL br%0d_cond: pc=%h done=%b rdy=%b tk=%b",
                         k, pc_out, done, op_ready, taken);
            end else passed++;
            cond_in = conds[k];
            tick();
            cond_in = $urandom;
            exp_pc  = conds[k] ? 32'h10 + sext19({13'h0, offs[k]}) : 32'h10;
            total++;
            if (pc_out !== exp_pc || taken !== conds[k] || done !== 1'b1) begin
                $display("FAIL br%0d_done: pc=%h tk=%b done=%b want %h/%b/1",
                         k, pc_out, taken, done, exp_pc, conds[k]);
            end else passed++;
            tick();
            total++;
            if (done !== 1'b0 || taken !== conds[k] || op_ready !== 1'b1) begin
                $display("FAIL br%0d_after: done=%b tk=%b rdy=%b", k, done,
                         taken, op_ready);
            end else passed++;
            m_pc = exp_pc;
            m_taken = conds[k];
        end
    endtask

    function automatic logic state_cond_ok();
        return (pc_out === 32'h10 && done === 1'b0 &&
                op_ready === 1'b0 && taken === 1'b0);
    endfunction

    task automatic test_jal();
        set_pc(32'h20);
        op_valid = 1'b1;
        op_code  = 2'b11;
        bus_in   = 32'h400;
        tick();
        op_valid = 1'b0;
        bus_in   = 32'h1234_5678;
        total++;
        if (pc_out !== 32'h400 || link_out !== 32'h20 ||
            link_we !== 1'b1 || done !== 1'b1) begin
            $display("FAIL jal: pc=%h lnk=%h lwe=%b done=%b want 400/20/1/1",
                     pc_out, link_out, link_we, done);
        end else passed++;
        tick();
        total++;
        if (pc_out !== 32'h400 || link_we !== 1'b0 || done !== 1'b0) begin
            $display("FAIL jal_after: pc=%h lwe=%b done=%b want 400/0/0",
                     pc_out, link_we, done);
        end else passed++;
        m_pc = 32'h400;
        m_link = 32'h20;
        m_taken = 1'b0;
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFF);
        op_valid = 1'b1;
        op_code  = 2'b00;
        tick();
        op_valid = 1'b0;
        total++;
        if (pc_out !== 32'h0 || done !== 1'b1) begin
            $display("FAIL inc_wrap: pc=%h done=%b want 0/1", pc_out, done);
        end else passed++;
        tick();
        set_pc(32'hDEAD_BEEF);
        total++;
        if (pc_out !== 32'hDEAD_BEEF) begin
            $display("FAIL jr: pc=%h want deadbeef", pc_out);
        end else passed++;
    endtask

    task automatic test_clear_mid();
        set_pc(32'h10);
        op_valid = 1'b1;
        op_code  = 2'b01;
        ir       = 32'h0000_000C;
        tick();
        op_valid = 1'b0;
        cond_in  = 1'b1;
        #2 clear = 1'b1;
        #1;
        total++;
        if (pc_out !== 32'h0 || op_ready !== 1'b1 ||
            taken !== 1'b0 || done !== 1'b0) begin
            $display("FAIL clear_async: pc=%h rdy=%b tk=%b done=%b",
                     pc_out, op_ready, taken, done);
        end else passed++;
        tick();
        clear = 1'b0;
        tick();
        total++;
        if (pc_out !== 32'h0 || done !== 1'b0 || op_ready !== 1'b1) begin
            $display("FAIL clear_after: pc=%h done=%b rdy=%b want 0/0/1",
                     pc_out, done, op_ready);
        end else passed++;
        m_pc = 0; m_link = 0; m_taken = 0;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] irv;
        logic [31:0] busv;
        logic        cv;
        int          lat;
        int          n;
        for (int t = 0; t < 40; t++) begin
            op   = 2'($urandom_range(0, 3));
            irv  = $urandom;
            busv = $urandom;
            cv   = 1'($urandom);
            if (t == 0) begin
                op = 2'b01; irv[18:0] = 19'h40000; cv = 1'b1;
            end
            case (op)
                2'b00: begin m_pc = m_pc + 1; m_taken = 0; end
                2'b01: begin
                    m_taken = cv;
                    if (cv) m_pc = m_pc + sext19(irv);
                end
                2'b10: begin m_pc = busv; m_taken = 0; end
                default: begin m_link = m_pc; m_pc = busv; m_taken = 0; end
            endcase
            lat = (op == 2'b01) ? 2 : 1;
            op_valid = 1'b1;
            op_code  = op;
            ir       = irv;
            bus_in   = busv;
            cond_in  = 1'($urandom);
            tick();
            op_valid = 1'b0;
            op_code  = 2'($urandom);
            ir       = $urandom;
            bus_in   = $urandom;
            cond_in  = cv;
            n = 1;
            while (done !== 1'b1 && n < 4) begin
                tick();
                cond_in = 1'($urandom);
                n++;
            end
            total++;
            if (done !== 1'b1 || n != lat) begin
                $display("FAIL rnd%0d_latency: done=%b cycles=%0d want %0d",
                         t, done, n, lat);
            end else passed++;
            total++;
            if (pc_out !== m_pc || taken !== m_taken || link_out !== m_link ||
                link_we !== (op == 2'b11)) begin
                $display("FAIL rnd%0d op=%0d: pc=%h tk=%b lnk=%h lwe=%b want %h/%b/%h/%b",
                         t, op, pc_out, taken, link_out, link_we,
                         m_pc, m_taken, m_link, (op == 2'b11));
            end else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_branch();
        test_jal();
        test_wrap();
        test_clear_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
